// File: rtl/sys_ce_reset_gen.sv
// -----------------------------------------------------------------------------
// sys_ce_reset_gen
//
// Lock-qualified system reset and fractional clock-enable generator. It sits
// directly behind the core PLL and is the only place pll_locked is sampled.
//
// pll_locked is brought into the clk_sys domain through a SYNC_STAGES flop
// chain. Every later decision uses the synchronised copy (locked_s).
// Once lock has been seen, sys_rst is held high for HOLD_CYCLES more cycles
// before the core is released.
//
// While running, two phase accumulators produce single-cycle enable pulses.
// Their rate is f_clk_sys * INC / 2^ACC_W.
//
// Parameters
//   ACC_W        phase accumulator width
//   INC_A/INC_B  per-cycle accumulator increments for ce_a / ce_b
//   HOLD_CYCLES  cycles sys_rst stays high after lock is seen (>= 1)
//   SYNC_STAGES  flops in the pll_locked synchroniser (>= 2)
//
// Ports
//   clk_sys       in   system clock (PLL output), sole clock
//   reset         in   synchronous active-high block reset
//   pll_locked    in   PLL lock flag, asynchronous to clk_sys
//   sys_rst       out  synchronous active-high reset to the core
//   ce_a          out  single-cycle enable pulse, channel A
//   ce_b          out  single-cycle enable pulse, channel B
//   running       out  high while the FSM is in RUN
//   lockloss_cnt  out  [7:0] saturating count of lock losses while running
//                      (present only when SYS_CE_LOCKLOSS_CNT_EN is defined)
//
// Optional feature macro: SYS_CE_LOCKLOSS_CNT_EN
// -----------------------------------------------------------------------------
module sys_ce_reset_gen #(
  parameter int               ACC_W       = 32,
  parameter logic [ACC_W-1:0] INC_A       = {ACC_W{1'b0}},
  parameter logic [ACC_W-1:0] INC_B       = {ACC_W{1'b0}},
  parameter int               HOLD_CYCLES = 1024,
  parameter int               SYNC_STAGES = 2
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       pll_locked,
  output logic       sys_rst,
  output logic       ce_a,
  output logic       ce_b,
  output logic       running
`ifdef SYS_CE_LOCKLOSS_CNT_EN
  ,
  output logic [7:0] lockloss_cnt
`endif
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [CNT_W-1:0]       hold_cnt_r;
  logic [CNT_W-1:0]       hold_cnt_nxt_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   locked_s;
  logic [ACC_W-1:0]       acc_a_r;
  logic [ACC_W-1:0]       acc_b_r;
  logic [ACC_W:0]         sum_a_s;
  logic [ACC_W:0]         sum_b_s;
  logic                   ce_a_r;
  logic                   ce_b_r;
  logic                   run_s;

  // Synchroniser chain bringing pll_locked into the clk_sys domain.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign locked_s = sync_r[SYNC_STAGES-1];

  // FSM state and hold-counter registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_r    <= ST_WAIT_LOCK;
      hold_cnt_r <= CNT_ZERO;
    end else begin
      state_r    <= state_nxt_s;
      hold_cnt_r <= hold_cnt_nxt_s;
    end
  end

  // Next-state logic. In HOLD a loss of lock wins over reaching the count,
  // so a glitch always restarts the full hold from WAIT_LOCK.
  always_comb begin
    state_nxt_s    = state_r;
    hold_cnt_nxt_s = hold_cnt_r;
    case (state_r)
      ST_WAIT_LOCK: begin
        hold_cnt_nxt_s = CNT_ZERO;
        if (locked_s) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_WAIT_LOCK;
        end
      end
      ST_HOLD: begin
        if (!locked_s) begin
          state_nxt_s    = ST_WAIT_LOCK;
          hold_cnt_nxt_s = CNT_ZERO;
        end else if (hold_cnt_r == HOLD_LAST) begin
          state_nxt_s    = ST_RUN;
          hold_cnt_nxt_s = CNT_ZERO;
        end else begin
          state_nxt_s    = ST_HOLD;
          hold_cnt_nxt_s = hold_cnt_r + CNT_ONE;
        end
      end
      ST_RUN: begin
        hold_cnt_nxt_s = CNT_ZERO;
        if (!locked_s) begin
          state_nxt_s = ST_WAIT_LOCK;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s    = ST_WAIT_LOCK;
        hold_cnt_nxt_s = CNT_ZERO;
      end
    endcase
  end

  assign run_s   = (state_r == ST_RUN);
  assign sys_rst = ~run_s;
  assign running = run_s;

  // The carry out of the widened add is the enable pulse for the next cycle.
  assign sum_a_s = {1'b0, acc_a_r} + {1'b0, INC_A};
  assign sum_b_s = {1'b0, acc_b_r} + {1'b0, INC_B};

  // Phase accumulators; they are held at zero outside RUN so that every RUN
  // entry starts from the same phase.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      acc_a_r <= {ACC_W{1'b0}};
      acc_b_r <= {ACC_W{1'b0}};
      ce_a_r  <= 1'b0;
      ce_b_r  <= 1'b0;
    end else if (run_s) begin
      acc_a_r <= sum_a_s[ACC_W-1:0];
      acc_b_r <= sum_b_s[ACC_W-1:0];
      ce_a_r  <= sum_a_s[ACC_W];
      ce_b_r  <= sum_b_s[ACC_W];
    end else begin
      acc_a_r <= {ACC_W{1'b0}};
      acc_b_r <= {ACC_W{1'b0}};
      ce_a_r  <= 1'b0;
      ce_b_r  <= 1'b0;
    end
  end

  // A carry registered on the last RUN cycle would otherwise appear in the
  // first cycle after leaving RUN; gating with run_s suppresses that tail.
  assign ce_a = ce_a_r & run_s;
  assign ce_b = ce_b_r & run_s;

`ifdef SYS_CE_LOCKLOSS_CNT_EN
  logic [7:0] lockloss_cnt_r;
  logic       lockloss_evt_s;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      sat_inc8 = 8'hFF;
    end else begin
      sat_inc8 = v + 8'd1;
    end
  endfunction

  // RUN is only ever left through a lock loss (or reset, which clears the count).
  assign lockloss_evt_s = run_s & ~locked_s;

  // Saturating lock-loss counter, cleared only by reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      lockloss_cnt_r <= 8'd0;
    end else if (lockloss_evt_s) begin
      lockloss_cnt_r <= sat_inc8(lockloss_cnt_r);
    end else begin
      lockloss_cnt_r <= lockloss_cnt_r;
    end
  end

  assign lockloss_cnt = lockloss_cnt_r;
`endif

endmodule

// File: tb/tb_sys_ce_reset_gen.sv
// -----------------------------------------------------------------------------
// tb_sys_ce_reset_gen
//
// Self-checking bench for sys_ce_reset_gen with HOLD_CYCLES=16 and
// SYNC_STAGES=2. The release latency is 2 + 1 + 16 = 19 cycles.
//
// Two instances share all inputs:
//   dut   INC_A = 2^31,       INC_B = 0
//   dut2  INC_A = 2^31,       INC_B = 0x55555555
//
// A per-cycle vector table covers the reset state, the first lock-up and
// a reset while running. Hand-written sequences follow for lock loss,
// a glitch during HOLD, the ce_b rate, counter saturation (with
// SYS_CE_LOCKLOSS_CNT_EN) and random lock toggling.
// -----------------------------------------------------------------------------
module tb_sys_ce_reset_gen;

  localparam int LAT       = 19;
  localparam int SEEN_NEED = 17;
  localparam int NVEC      = 88;

  logic clk_sys    = 1'b0;
  logic reset      = 1'b1;
  logic pll_locked = 1'b0;
  logic sys_rst, ce_a, ce_b, running;
  logic sys_rst2, ce_a2, ce_b2, running2;
`ifdef SYS_CE_LOCKLOSS_CNT_EN
  logic [7:0] lockloss_cnt, lockloss_cnt2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_sys = ~clk_sys;

  sys_ce_reset_gen #(
    .ACC_W(32), .INC_A(32'h8000_0000), .INC_B(32'h0000_0000),
    .HOLD_CYCLES(16), .SYNC_STAGES(2)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .pll_locked(pll_locked),
    .sys_rst(sys_rst), .ce_a(ce_a), .ce_b(ce_b), .running(running)
`ifdef SYS_CE_LOCKLOSS_CNT_EN
    , .lockloss_cnt(lockloss_cnt)
`endif
  );

  sys_ce_reset_gen #(
    .ACC_W(32), .INC_A(32'h8000_0000), .INC_B(32'h5555_5555),
    .HOLD_CYCLES(16), .SYNC_STAGES(2)
  ) dut2 (
    .clk_sys(clk_sys), .reset(reset), .pll_locked(pll_locked),
    .sys_rst(sys_rst2), .ce_a(ce_a2), .ce_b(ce_b2), .running(running2)
`ifdef SYS_CE_LOCKLOSS_CNT_EN
    , .lockloss_cnt(lockloss_cnt2)
`endif
  );

  typedef struct {
    logic rst;
    logic lock;
    logic e_sys_rst;
    logic e_ce_a;
  } vec_t;

  vec_t vecs [NVEC];

  // Expected outputs c edges after lock is first sampled with reset low.
  function automatic vec_t mk(input int c);
    vec_t v;
    v.rst       = 1'b0;
    v.lock      = 1'b1;
    v.e_sys_rst = (c < LAT);
    v.e_ce_a    = (c >= LAT + 2) && (((c - LAT) % 2) == 0);
    return v;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %b required %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Drop lock while running: sys_rst rises on the 3rd edge, with no ce tail.
  task automatic lose_lock(input logic [7:0] exp_cnt);
    pll_locked = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      check1("t4_sys_rst", sys_rst, (k == 3));
    end
    check1("t4_ce_a", ce_a, 1'b0);
    check1("t4_ce_b2", ce_b2, 1'b0);
    check1("t4_running", running, 1'b0);
`ifdef SYS_CE_LOCKLOSS_CNT_EN
    check8("t4_lockloss_cnt", lockloss_cnt, exp_cnt);
`else
    if (exp_cnt == 8'd0) begin
      check1("t4_rst2", sys_rst2, 1'b1);
    end else begin
      check1("t4_rst2", sys_rst2, 1'b1);
    end
`endif
  endtask

  // Raise lock from a fully unlocked state: release exactly LAT edges later.
  task automatic acquire_lock();
    pll_locked = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      step();
      check1("lock_sys_rst", sys_rst, (k < LAT));
    end
  endtask

  initial begin
    int ce_cnt;
    int adj_cnt;
    int not_run;
    int ceb0_cnt;
    logic prev_ce;
    int cnt0, cnt1, cnt2;
    int width;
    logic lk;

    // Vector table: reset state, first lock-up, then reset while running.
    for (int i = 0; i < 3; i++) vecs[i] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 3; i < 45; i++) vecs[i] = mk(i - 2);
    vecs[45] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 46; i < NVEC; i++) vecs[i] = mk(i - 45);

    for (int i = 0; i < NVEC; i++) begin
      reset      = vecs[i].rst;
      pll_locked = vecs[i].lock;
      step();
      check1("tbl_sys_rst", sys_rst, vecs[i].e_sys_rst);
      check1("tbl_running", running, ~vecs[i].e_sys_rst);
      check1("tbl_ce_a", ce_a, vecs[i].e_ce_a);
      check1("tbl_ce_b", ce_b, 1'b0);
      check1("tbl_sys_rst2", sys_rst2, vecs[i].e_sys_rst);
      check1("tbl_ce_a2", ce_a2, vecs[i].e_ce_a);
`ifdef SYS_CE_LOCKLOSS_CNT_EN
      check8("tbl_lockloss_cnt", lockloss_cnt, 8'd0);
`endif
    end

    // Lock loss while running (ce_a would pulse on the exit cycle if ungated).
    lose_lock(8'd1);

    // Glitch at HOLD count 10: full hold is restarted after the relock.
    pll_locked = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      step();
      check1("t3_pre_sys_rst", sys_rst, 1'b1);
    end
    pll_locked = 1'b0;
    step();
    check1("t3_glitch_sys_rst", sys_rst, 1'b1);
    acquire_lock();

    lose_lock(8'd2);
    acquire_lock();

    // ce_b rate over 3000 running cycles with INC_B = 0x55555555.
    ce_cnt   = 0;
    adj_cnt  = 0;
    not_run  = 0;
    ceb0_cnt = 0;
    prev_ce  = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      step();
      if (ce_b2) ce_cnt++;
      if (ce_b2 && prev_ce) adj_cnt++;
      if (!running2) not_run++;
      if (ce_b) ceb0_cnt++;
      prev_ce = ce_b2;
    end
    n_cmp++;
    if (ce_cnt < 999 || ce_cnt > 1001) begin
      n_err++;
      $display("FAIL t2_ce_b_count: actual %0d required 1000 +-1", ce_cnt);
    end
    n_cmp++;
    if (adj_cnt != 0) begin
      n_err++;
      $display("FAIL t2_ce_b_adjacent: actual %0d required 0", adj_cnt);
    end
    n_cmp++;
    if (not_run != 0) begin
      n_err++;
      $display("FAIL t2_running: actual %0d idle cycles required 0", not_run);
    end
    n_cmp++;
    if (ceb0_cnt != 0) begin
      n_err++;
      $display("FAIL t1_ce_b_zero_inc: actual %0d pulses required 0", ceb0_cnt);
    end

`ifdef SYS_CE_LOCKLOSS_CNT_EN
    // Drive the lock-loss counter past 255 and confirm it saturates.
    for (int d = 3; d <= 256; d++) begin
      lose_lock((d > 255) ? 8'd255 : 8'(d));
      acquire_lock();
    end
`endif

    // Random lock toggling. sys_rst may be low only after locked_s has been
    // seen high for 17 consecutive edges (1 to enter HOLD + 16 in HOLD).
    // locked_s lags pll_locked by two edges.
    reset      = 1'b1;
    pll_locked = 1'b0;
    step();
    reset = 1'b0;
    cnt0  = 0;
    cnt1  = 0;
    cnt2  = 0;
    width = 0;
    lk    = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      if (width == 0) begin
        lk    = ~lk;
        width = $urandom_range(50, 1);
      end
      width--;
      pll_locked = lk;
      step();
      cnt2 = cnt1;
      cnt1 = cnt0;
      cnt0 = lk ? ((cnt0 < 1000) ? cnt0 + 1 : cnt0) : 0;
      check1("t6_sys_rst", sys_rst, (cnt2 < SEEN_NEED));
      check1("t6_running", running, (cnt2 >= SEEN_NEED));
      check1("t6_ce_gate", ce_a & sys_rst, 1'b0);
      check1("t6_x", $isunknown({sys_rst, ce_a, ce_b, running,
                                 sys_rst2, ce_a2, ce_b2, running2}), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
